// File: rtl/coeff_load_pkg.sv
// Shared FSM state type and sizing helpers for the coefficient loader.
// Build option COEFF_LOAD_CHK_EN (see coeff_load_ctrl) does not change anything here.
package coeff_load_pkg;

    localparam int NUM_COEFF_DEF = 25;
    localparam int COEFF_W_DEF   = 16;
    localparam int IDX_W         = $clog2(NUM_COEFF_DEF);
    localparam int CHK_W         = COEFF_W_DEF + 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Index width that stays legal for a single-entry table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coeff_load_ctrl_rd_align_pipe.sv
// Delays the {valid, index} of each issued BRAM read by DEPTH cycles so that
// the index arrives together with the read data.
module rd_align_pipe
    import coeff_load_pkg::*;
#(
    parameter int DEPTH    = 1,
    parameter int IDX_BITS = IDX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_vld,
    input  logic [IDX_BITS-1:0] i_idx,
    output logic                o_vld,
    output logic [IDX_BITS-1:0] o_idx
);

    logic [DEPTH-1:0]    r_vld;
    logic [IDX_BITS-1:0] r_idx [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_idx[0] <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/coeff_load_ctrl.sv
// Per-frame coefficient loader: fetches NUM_COEFF BRAM words into a shadow bank and
// commits them atomically to the active FIR taps. Define COEFF_LOAD_CHK_EN for the chk_o checksum.
module coeff_load_ctrl
    import coeff_load_pkg::*;
#(
    parameter int NUM_COEFF = NUM_COEFF_DEF,
    parameter int COEFF_W   = COEFF_W_DEF,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vs_i,
    input  logic                          arm_i,
    input  logic                          ovr_clr_i,
    output logic                          bram_en_o,
    output logic [ADDR_W-1:0]             bram_addr_o,
    input  logic [COEFF_W-1:0]            bram_dout_i,
    output logic [NUM_COEFF*COEFF_W-1:0]  coeff_o,
    output logic                          coeff_vld_o,
    output logic                          busy_o,
    output logic                          commit_o,
    output logic                          overrun_o,
    output logic [COEFF_W+4:0]            chk_o
);

    localparam int                 L_IDX_W    = idx_width(NUM_COEFF);
    localparam int                 L_CHK_W    = CHK_W + (COEFF_W - COEFF_W_DEF);
    localparam logic [L_IDX_W-1:0] LAST_IDX   = L_IDX_W'(NUM_COEFF - 1);
    localparam logic [1:0]         LAST_DRAIN = 2'(RD_LAT - 1);

    state_t                       r_state;
    state_t                       w_next;
    logic                         r_vs_dly;
    logic                         w_edge;
    logic                         w_start;
    logic                         r_armed;
    logic                         r_overrun;
    logic                         r_vld;
    logic [L_IDX_W-1:0]           r_idx;
    logic [1:0]                   r_drain;
    logic [COEFF_W-1:0]           r_shadow [NUM_COEFF];
    logic [NUM_COEFF*COEFF_W-1:0] r_active;
    logic                         w_cap_vld;
    logic [L_IDX_W-1:0]           w_cap_idx;

    // The first frame after reset always loads, even without an arm.
    assign w_edge  = vs_i & ~r_vs_dly;
    assign w_start = w_edge & (r_state == IDLE) & (r_armed | ~r_vld);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = FETCH;
            FETCH:   if (r_idx == LAST_IDX) w_next = DRAIN;
            DRAIN:   if (r_drain == LAST_DRAIN) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bram_en_o = 1'b0;
        busy_o    = 1'b0;
        commit_o  = 1'b0;
        case (r_state)
            FETCH: begin
                bram_en_o = 1'b1;
                busy_o    = 1'b1;
            end
            DRAIN: begin
                busy_o    = 1'b1;
            end
            COMMIT: begin
                busy_o    = 1'b1;
                commit_o  = 1'b1;
            end
            default: begin
                busy_o    = 1'b0;
            end
        endcase
    end

    assign bram_addr_o = ADDR_W'(r_idx);

    // The index stops on the last address so the address stays put through DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_drain <= '0;
        end else begin
            if (w_start) begin
                r_idx <= '0;
            end else if (r_state == FETCH && r_idx != LAST_IDX) begin
                r_idx <= r_idx + L_IDX_W'(1);
            end
            if (r_state == DRAIN) begin
                r_drain <= r_drain + 2'd1;
            end else begin
                r_drain <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_dly  <= 1'b0;
            r_armed   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_vs_dly <= vs_i;
            if (arm_i) begin
                r_armed <= 1'b1;
            end else if (w_start) begin
                r_armed <= 1'b0;
            end
            if (w_edge && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    rd_align_pipe #(
        .DEPTH    (RD_LAT),
        .IDX_BITS (L_IDX_W)
    ) u_align (
        .clk   (clk),
        .rst_n (rst),
        .i_vld (bram_en_o),
        .i_idx (r_idx),
        .o_vld (w_cap_vld),
        .o_idx (w_cap_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_cap_vld) begin
            r_shadow[w_cap_idx] <= bram_dout_i;
        end
    end

    // The active bank only moves in COMMIT, so the taps stay fixed across a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= '0;
            r_vld    <= 1'b0;
        end else if (r_state == COMMIT) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                r_active[k*COEFF_W +: COEFF_W] <= r_shadow[k];
            end
            r_vld <= 1'b1;
        end
    end

    assign coeff_o     = r_active;
    assign coeff_vld_o = r_vld;
    assign overrun_o   = r_overrun;

`ifdef COEFF_LOAD_CHK_EN
    logic [L_CHK_W-1:0] r_acc;
    logic [L_CHK_W-1:0] r_chk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_chk <= '0;
        end else begin
            if (w_start) begin
                r_acc <= '0;
            end else if (w_cap_vld) begin
                r_acc <= r_acc + L_CHK_W'($signed(bram_dout_i));
            end
            if (r_state == COMMIT) begin
                r_chk <= r_acc;
            end
        end
    end

    assign chk_o = r_chk;
`else
    assign chk_o = '0;
`endif

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Bench for coeff_load_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share one BRAM image
// and are compared against a frame-level model of the load/arm/overrun rules.
`timescale 1ns/1ps
module tb_coeff_load_ctrl;

    localparam int NC    = 25;
    localparam int CW    = 16;
    localparam int AW    = 11;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int BW    = NC * CW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vs  = 1'b0;
    logic arm = 1'b0;
    logic clr = 1'b0;

    logic          enA, enB;
    logic [AW-1:0] addrA, addrB;
    logic [CW-1:0] doutA, doutB;
    logic [BW-1:0] coeffA, coeffB;
    logic          vldA, vldB, busyA, busyB, comA, comB, ovrA, ovrB;
    logic [CW+4:0] chkA, chkB;

    logic [CW-1:0] mem [NC];
    logic [CW-1:0] pB1, pB2;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] expBank [NC];
    logic          expVld;
    logic          expArmed;
    logic          expOvr;
    logic [CW+4:0] expChk;

    coeff_load_ctrl #(.NUM_COEFF(NC), .COEFF_W(CW), .ADDR_W(AW), .RD_LAT(LAT_A)) dutA (
        .clk(clk), .rst(rst), .vs_i(vs), .arm_i(arm), .ovr_clr_i(clr),
        .bram_en_o(enA), .bram_addr_o(addrA), .bram_dout_i(doutA),
        .coeff_o(coeffA), .coeff_vld_o(vldA), .busy_o(busyA), .commit_o(comA),
        .overrun_o(ovrA), .chk_o(chkA)
    );

    coeff_load_ctrl #(.NUM_COEFF(NC), .COEFF_W(CW), .ADDR_W(AW), .RD_LAT(LAT_B)) dutB (
        .clk(clk), .rst(rst), .vs_i(vs), .arm_i(arm), .ovr_clr_i(clr),
        .bram_en_o(enB), .bram_addr_o(addrB), .bram_dout_i(doutB),
        .coeff_o(coeffB), .coeff_vld_o(vldB), .busy_o(busyB), .commit_o(comB),
        .overrun_o(ovrB), .chk_o(chkB)
    );

    always #5 clk = ~clk;

    // BRAM port-B models with one and three cycles of read latency.
    always @(posedge clk) begin
        if (enA) doutA <= mem[addrA[4:0]];
        if (enB) pB1 <= mem[addrB[4:0]];
        pB2   <= pB1;
        doutB <= pB2;
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] packBank();
        logic [BW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*CW +: CW] = expBank[k];
        return v;
    endfunction

    function automatic logic [CW+4:0] sumMem();
        int s = 0;
        for (int k = 0; k < NC; k++) s += $signed(mem[k]);
        return s[CW+4:0];
    endfunction

    function automatic logic [CW+4:0] chkExpected();
`ifdef COEFF_LOAD_CHK_EN
        return expChk;
`else
        return '0;
`endif
    endfunction

    task automatic checkSteady(input string tag);
        checkOutput({tag, ".coeffA"}, coeffA, packBank());
        checkOutput({tag, ".coeffB"}, coeffB, packBank());
        checkOutput({tag, ".vldA"}, vldA, expVld);
        checkOutput({tag, ".vldB"}, vldB, expVld);
        checkOutput({tag, ".ovrA"}, ovrA, expOvr);
        checkOutput({tag, ".ovrB"}, ovrB, expOvr);
        checkOutput({tag, ".chkA"}, chkA, chkExpected());
        checkOutput({tag, ".chkB"}, chkB, chkExpected());
    endtask

    task automatic randomizeMem();
        for (int k = 0; k < NC; k++) mem[k] = 16'($urandom());
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        expArmed = 1'b1;
    endtask

    task automatic pulseClr(input string tag);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expOvr = 1'b0;
        tick();
        checkOutput({tag, ".clrA"}, ovrA, 1'b0);
        checkOutput({tag, ".clrB"}, ovrB, 1'b0);
    endtask

    // One frame: vs rises in cycle 0; optional second edge while loading.
    task automatic applyStimulus(input string tag, input bit armWithEdge, input int vsLen,
                                 input int secondEdge, input bit clrAtSecond);
        bit load;
        load = expArmed || !expVld;
        vs   = 1'b1;
        arm  = armWithEdge;
        if (armWithEdge) expArmed = 1'b1;
        else if (load)   expArmed = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checkOutput({tag, ".enA"}, enA, load && c <= NC);
            checkOutput({tag, ".enB"}, enB, load && c <= NC);
            if (load && c <= NC) begin
                checkOutput({tag, ".addrA"}, addrA, c - 1);
                checkOutput({tag, ".addrB"}, addrB, c - 1);
            end
            checkOutput({tag, ".busyA"}, busyA, load && c <= NC + 1 + LAT_A);
            checkOutput({tag, ".busyB"}, busyB, load && c <= NC + 1 + LAT_B);
            checkOutput({tag, ".comA"}, comA, load && c == NC + 1 + LAT_A);
            checkOutput({tag, ".comB"}, comB, load && c == NC + 1 + LAT_B);
            if (c == 1) arm = 1'b0;
            if (c == vsLen) vs = 1'b0;
            if (secondEdge > 0 && c == secondEdge) begin
                vs  = 1'b1;
                clr = clrAtSecond;
            end
            if (secondEdge > 0 && c == secondEdge + 1) begin
                vs  = 1'b0;
                clr = 1'b0;
            end
        end
        if (load) begin
            for (int k = 0; k < NC; k++) expBank[k] = mem[k];
            expVld = 1'b1;
            expChk = sumMem();
            if (secondEdge > 0) expOvr = 1'b1;
        end
        checkSteady(tag);
    endtask

    task automatic resetMidLoad(input int atCycle);
        vs = 1'b1;
        expArmed = 1'b0;
        for (int c = 1; c <= atCycle; c++) begin
            tick();
            if (c == 2) vs = 1'b0;
        end
        checkOutput("rstmid.busyBefore", busyA, 1'b1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NC; k++) expBank[k] = '0;
        expVld = 1'b0;
        expOvr = 1'b0;
        expChk = '0;
        checkOutput("rstmid.busyA", busyA, 1'b0);
        checkOutput("rstmid.busyB", busyB, 1'b0);
        checkOutput("rstmid.enA", enA, 1'b0);
        checkOutput("rstmid.enB", enB, 1'b0);
        checkSteady("rstmid");
        tick();
        rst = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int choice;
        for (int k = 0; k < NC; k++) begin
            mem[k]     = 16'(k + 1);
            expBank[k] = '0;
        end
        expVld   = 1'b0;
        expArmed = 1'b0;
        expOvr   = 1'b0;
        expChk   = '0;

        tick();
        tick();
        checkOutput("reset.enA", enA, 1'b0);
        checkOutput("reset.addrA", addrA, 0);
        checkOutput("reset.busyA", busyA, 1'b0);
        checkOutput("reset.comA", comA, 1'b0);
        checkSteady("reset");
        rst = 1'b1;
        tick();
        tick();

        $display("[TB] first load after reset");
        applyStimulus("t1", 1'b0, 2, 0, 1'b0);
        checkOutput("t1.coeff12", coeffA[12*CW +: CW], 16'd13);
`ifdef COEFF_LOAD_CHK_EN
        checkOutput("t1.chk325", chkA, 325);
`endif

        $display("[TB] reload gated by arm");
        mem[12] = 16'hFF00;
        tick();
        applyStimulus("t2a", 1'b0, 3, 0, 1'b0);
        checkOutput("t2a.coeff12", coeffA[12*CW +: CW], 16'd13);
        pulseArm();
        applyStimulus("t2b", 1'b0, 1, 0, 1'b0);
        checkOutput("t2b.coeff12", coeffA[12*CW +: CW], 16'hFF00);
        checkOutput("t2b.coeff11", coeffB[11*CW +: CW], 16'd12);

        $display("[TB] overrun and clear");
        pulseArm();
        applyStimulus("t3a", 1'b0, 2, 10, 1'b0);
        pulseClr("t3a");
        randomizeMem();
        pulseArm();
        applyStimulus("t3b", 1'b0, 2, 12, 1'b1);
        pulseClr("t3b");

        $display("[TB] reset in the middle of a load");
        randomizeMem();
        pulseArm();
        resetMidLoad(15);
        applyStimulus("t4", 1'b0, 2, 0, 1'b0);

        $display("[TB] arm coincident with start");
        pulseArm();
        randomizeMem();
        applyStimulus("t5a", 1'b1, 1, 0, 1'b0);
        randomizeMem();
        applyStimulus("t5b", 1'b0, 2, 0, 1'b0);
        randomizeMem();
        applyStimulus("t5c", 1'b0, 2, 0, 1'b0);

        $display("[TB] random frames");
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) randomizeMem();
            choice = $urandom_range(0, 2);
            if (choice == 1) pulseArm();
            applyStimulus("rnd", choice == 2, $urandom_range(1, 4), 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
